// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches 16-bit instructions, dispatches a one-hot start to the per-opcode
// execution FSM, waits for its done, and flags HALT, illegal opcodes and hung units.
module instr_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [15:0]     OP_MASK  = 16'h00FF,
    parameter int              TIMEOUT  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic [PC_W-1:0] mem_addr,
    output logic            mem_rd,
    input  logic [15:0]     mem_rdata,
    input  logic            mem_ack,
    output logic [15:0]     ir,
    output logic [15:0]     exec_start,
    input  logic [15:0]     exec_done,
    output logic            busy,
    output logic            halted,
    output logic            fault,
    output logic [1:0]      fault_code,
    output logic [15:0]     retired
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WAIT, HALT, FAULT} state_t;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d, retired_q, retired_d;
    logic [7:0]      timer_q, timer_d;
    logic [1:0]      fault_code_q, fault_code_d;
    logic [3:0]      op;
    logic            done, legal;
    assign op    = ir_q[15:12];
    assign done  = exec_done[op];
    assign legal = OP_MASK[op];
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        timer_d      = timer_q;
        retired_d    = retired_q;
        fault_code_d = fault_code_q;
        case (state_q)
            IDLE: state_d = run ? FETCH : IDLE;
            FETCH: if (mem_ack) begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                state_d      = (op == 4'hF) ? HALT : legal ? EXEC : FAULT;
                fault_code_d = (op != 4'hF && !legal) ? 2'b01 : fault_code_q;
            end
            EXEC: begin
                timer_d = '0;
                state_d = WAIT;
            end
            // done takes priority over a timeout on the same edge
            WAIT: if (done) begin
                retired_d = retired_q + 1'b1;
                state_d   = run ? FETCH : IDLE;
            end else if (timer_q == TO_LAST) begin
                state_d      = FAULT;
                fault_code_d = 2'b10;
            end else begin
                timer_d = timer_q + 1'b1;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            timer_q      <= '0;
            retired_q    <= '0;
            fault_code_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            timer_q      <= timer_d;
            retired_q    <= retired_d;
            fault_code_q <= fault_code_d;
        end
    end
    assign mem_addr   = pc_q;
    assign mem_rd     = state_q == FETCH;
    assign ir         = ir_q;
    assign exec_start = (state_q == EXEC) ? (16'h0001 << op) : 16'h0000;
    assign busy       = !(state_q inside {IDLE, HALT, FAULT});
    assign halted     = state_q == HALT;
    assign fault      = state_q == FAULT;
    assign fault_code = fault_code_q;
    assign retired    = retired_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed scenarios against a simple memory and done-responder model.
module tb_instr_sequencer;
    logic        clk = 1'b0;
    logic        rst, run, mem_rd, mem_ack, busy, halted, fault;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata, ir, exec_start, exec_done, retired;
    logic [1:0]  fault_code;
    logic [15:0] mem [256];
    logic [15:0] done_mask, stray, pend;
    int          ack_delay, done_delay, dcnt;
    int          wait_cnt = 0;
    int          checks = 0, errors = 0;

    instr_sequencer dut (
        .clk(clk), .rst(rst), .run(run), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .ir(ir), .exec_start(exec_start),
        .exec_done(exec_done), .busy(busy), .halted(halted), .fault(fault),
        .fault_code(fault_code), .retired(retired)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_rd && (wait_cnt >= ack_delay);
    always @(posedge clk) wait_cnt <= (mem_rd && !mem_ack) ? wait_cnt + 1 : 0;

    // done for the started unit arrives done_delay cycles into WAIT, for one cycle
    always @(posedge clk) begin
        if (rst) begin
            pend <= '0;
            dcnt <= 0;
        end else if (exec_start != 16'h0) begin
            pend <= exec_start & done_mask;
            dcnt <= done_delay;
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
        end else begin
            pend <= '0;
        end
    end
    assign exec_done = ((dcnt == 0) ? pend : 16'h0) | stray;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        stray = '0;
        ack_delay = 0;
        done_delay = 0;
        done_mask = 16'h0080;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [61:0] got;
        do_reset();
        got = {busy, mem_rd, halted, fault, fault_code, exec_start, ir, mem_addr, retired};
        checks++;
        if (got !== 62'h0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0", got);
        end
    endtask

    task automatic test_single();
        int n = 0, at = 0;
        logic [15:0] st = '0;
        do_reset();
        mem[0] = 16'h7005;
        mem[1] = 16'hF000;
        run = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (exec_start != 16'h0) begin
                n++;
                at = c;
                st = exec_start;
            end
        end
        checks++;
        if (n !== 1 || at !== 3 || st !== 16'h0080) begin
            errors++;
            $display("FAIL single_start: got n=%0d cycle=%0d val=%h expected n=1 cycle=3 val=0080", n, at, st);
        end
        checks++;
        if ({ir, mem_addr, mem_rd, retired} !== {16'h7005, 8'h01, 1'b1, 16'h0001}) begin
            errors++;
            $display("FAIL single_state: got ir=%h addr=%h rd=%b ret=%0d expected 7005 01 1 1", ir, mem_addr, mem_rd, retired);
        end
        run = 1'b0;
    endtask

    task automatic test_program();
        int starts = 0;
        do_reset();
        mem[0] = 16'h7001;
        mem[1] = 16'h7002;
        mem[2] = 16'hF000;
        run = 1'b1;
        for (int c = 0; c < 40 && !halted; c++) begin
            step();
            if (exec_start === 16'h0080) starts++;
        end
        checks++;
        if ({halted, fault, busy, mem_rd} !== 4'b1000 || starts !== 2) begin
            errors++;
            $display("FAIL program_halt: got h=%b f=%b busy=%b rd=%b starts=%0d expected 1 0 0 0 starts=2", halted, fault, busy, mem_rd, starts);
        end
        checks++;
        if (retired !== 16'd2 || mem_addr !== 8'h03) begin
            errors++;
            $display("FAIL program_count: got ret=%0d pc=%h expected 2 03", retired, mem_addr);
        end
        repeat (3) step();
        checks++;
        if ({halted, mem_rd, exec_start} !== {1'b1, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL halt_sticky: got h=%b rd=%b start=%h expected 1 0 0000", halted, mem_rd, exec_start);
        end
        run = 1'b0;
    endtask

    task automatic test_illegal();
        int starts = 0;
        do_reset();
        mem[0] = 16'hA000;
        run = 1'b1;
        for (int c = 0; c < 20 && !fault; c++) begin
            step();
            if (exec_start != 16'h0) starts++;
        end
        checks++;
        if ({fault, halted, busy, fault_code} !== 5'b10001 || starts !== 0) begin
            errors++;
            $display("FAIL illegal_fault: got f=%b h=%b busy=%b code=%b starts=%0d expected 1 0 0 01 0", fault, halted, busy, fault_code, starts);
        end
        checks++;
        if (ir !== 16'hA000 || mem_addr !== 8'h01 || retired !== 16'd0) begin
            errors++;
            $display("FAIL illegal_state: got ir=%h pc=%h ret=%0d expected A000 01 0", ir, mem_addr, retired);
        end
        run = 1'b0;
    endtask

    task automatic test_timeout();
        int n = 0;
        do_reset();
        mem[0] = 16'h3000;
        done_mask = 16'h0;
        run = 1'b1;
        for (int c = 0; c < 10 && exec_start == 16'h0; c++) step();
        checks++;
        if (exec_start !== 16'h0008) begin
            errors++;
            $display("FAIL timeout_start: got %h expected 0008", exec_start);
        end
        stray = 16'h0020;
        while (!fault && n < 40) begin
            step();
            n++;
        end
        stray = '0;
        checks++;
        if (n !== 17 || fault_code !== 2'b10) begin
            errors++;
            $display("FAIL timeout_fault: got cycles=%0d code=%b expected 17 10", n, fault_code);
        end
        checks++;
        if (retired !== 16'd0 || ir !== 16'h3000) begin
            errors++;
            $display("FAIL timeout_state: got ret=%0d ir=%h expected 0 3000", retired, ir);
        end
        run = 1'b0;
    endtask

    task automatic test_done_at_timeout();
        do_reset();
        mem[0] = 16'h7000;
        mem[1] = 16'hF000;
        done_delay = 15;
        run = 1'b1;
        for (int c = 0; c < 80 && !halted && !fault; c++) step();
        checks++;
        if ({halted, fault, retired} !== {1'b1, 1'b0, 16'd1}) begin
            errors++;
            $display("FAIL done_vs_timeout: got h=%b f=%b ret=%0d expected 1 0 1", halted, fault, retired);
        end
        run = 1'b0;
    endtask

    task automatic test_run_drop();
        int rd_cnt = 0;
        do_reset();
        mem[0] = 16'h7001;
        mem[1] = 16'h7002;
        done_delay = 3;
        run = 1'b1;
        for (int c = 0; c < 10 && exec_start == 16'h0; c++) step();
        step();
        run = 1'b0;
        for (int c = 0; c < 20 && busy; c++) step();
        checks++;
        if ({busy, mem_rd, halted, fault, mem_addr, retired} !== {4'b0000, 8'h01, 16'd1}) begin
            errors++;
            $display("FAIL run_drop: got busy=%b rd=%b pc=%h ret=%0d expected 0 0 01 1", busy, mem_rd, mem_addr, retired);
        end
        repeat (3) step();
        checks++;
        if ({busy, mem_rd, mem_addr} !== {2'b00, 8'h01}) begin
            errors++;
            $display("FAIL idle_hold: got busy=%b rd=%b pc=%h expected 0 0 01", busy, mem_rd, mem_addr);
        end
        ack_delay = 4;
        run = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (mem_rd && mem_addr == 8'h01) rd_cnt++;
        end
        checks++;
        if (rd_cnt !== 5) begin
            errors++;
            $display("FAIL slow_fetch_rd: got %0d cycles expected 5", rd_cnt);
        end
        step();
        checks++;
        if (ir !== 16'h7002 || mem_addr !== 8'h02 || mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL resume_fetch: got ir=%h pc=%h rd=%b expected 7002 02 0", ir, mem_addr, mem_rd);
        end
        run = 1'b0;
    endtask

    task automatic test_wrap_reset();
        logic [61:0] got;
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 16'h7000;
        run = 1'b1;
        for (int c = 0; c < 2000 && retired != 16'd255; c++) step();
        checks++;
        if (mem_addr !== 8'hFF || mem_rd !== 1'b1 || retired !== 16'd255) begin
            errors++;
            $display("FAIL wrap_pre: got pc=%h rd=%b ret=%0d expected FF 1 255", mem_addr, mem_rd, retired);
        end
        done_delay = 5;
        for (int c = 0; c < 10 && exec_start == 16'h0; c++) step();
        checks++;
        if (mem_addr !== 8'h00 || exec_start !== 16'h0080) begin
            errors++;
            $display("FAIL pc_wrap: got pc=%h start=%h expected 00 0080", mem_addr, exec_start);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        got = {busy, mem_rd, halted, fault, fault_code, exec_start, ir, mem_addr, retired};
        checks++;
        if (got !== 62'h0) begin
            errors++;
            $display("FAIL reset_mid_wait: got %h expected 0", got);
        end
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_program();
        test_illegal();
        test_timeout();
        test_done_at_timeout();
        test_run_drop();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
